// File: rtl/room_collision_checker_pkg.sv
// Shared types and play-area geometry for the room collision checker.
package room_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_W = 2'd2,
    DIR_E = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_Q_TL = 3'd2,
    S_Q_TR = 3'd3,
    S_Q_BL = 3'd4,
    S_Q_BR = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam int TILE_PX  = 32;
  localparam int SCREEN_W = 640;
  localparam int PLAY_TOP = 32;   // tile row 0 is the HUD band
  localparam int PLAY_BOT = 448;  // top of bottom wall row 14

  function automatic logic signed [11:0] sext4(input logic [3:0] v);
    return {{8{v[3]}}, v};
  endfunction

endpackage

// File: rtl/room_collision_checker.sv
// Probes the four corners of a proposed sprite box against an external tile
// lookup and reports an accepted move, a wall block, or a wrapped room exit.
module room_collision_checker
  import room_pkg::*;
#(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [9:0] cur_x,
  input  logic [9:0] cur_y,
  input  logic [3:0] dx,
  input  logic [3:0] dy,
  input  logic [2:0] room,
  output logic [9:0] query_x,
  output logic [9:0] query_y,
  output logic [2:0] query_room,
  input  logic       tile_wall,
  output logic       busy,
  output logic       done,
  output logic       blocked,
  output logic       exit_valid,
  output logic [1:0] exit_dir,
  output logic [9:0] new_x,
  output logic [9:0] new_y
);

  // One guard bit above the 11-bit signed position so box-edge sums never wrap.
  localparam logic signed [11:0] TOP_S = 12'(PLAY_TOP);
  localparam logic signed [11:0] BOT_S = 12'(PLAY_BOT);
  localparam logic signed [11:0] SCR_S = 12'(SCREEN_W);
  localparam logic signed [11:0] SW_S  = 12'(SPRITE_W);
  localparam logic signed [11:0] SH_S  = 12'(SPRITE_H);
  localparam logic [9:0]         OFS_X = 10'(SPRITE_W - 1);
  localparam logic [9:0]         OFS_Y = 10'(SPRITE_H - 1);

  state_t     state;
  logic [9:0] cx_r, cy_r, px_r, py_r;
  logic [3:0] dx_r, dy_r;
  logic [2:0] room_r;
  logic       wall_r;

  logic signed [11:0] px_c, py_c;
  logic               exit_n, exit_s, exit_w, exit_e, any_exit, hit;

  always_comb begin
    px_c     = $signed({2'b00, cx_r}) + sext4(dx_r);
    py_c     = $signed({2'b00, cy_r}) + sext4(dy_r);
    exit_n   = py_c < TOP_S;
    exit_s   = (py_c + SH_S) > BOT_S;
    exit_w   = px_c[11];
    exit_e   = (px_c + SW_S) > SCR_S;
    any_exit = exit_n | exit_s | exit_w | exit_e;
    hit      = wall_r | tile_wall;
  end

  always_comb begin
    query_x    = '0;
    query_y    = '0;
    query_room = room_r;
    case (state)
      S_Q_TL: begin query_x = px_r;         query_y = py_r;         end
      S_Q_TR: begin query_x = px_r + OFS_X; query_y = py_r;         end
      S_Q_BL: begin query_x = px_r;         query_y = py_r + OFS_Y; end
      S_Q_BR: begin query_x = px_r + OFS_X; query_y = py_r + OFS_Y; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cx_r       <= '0;
      cy_r       <= '0;
      dx_r       <= '0;
      dy_r       <= '0;
      room_r     <= '0;
      px_r       <= '0;
      py_r       <= '0;
      wall_r     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      blocked    <= 1'b0;
      exit_valid <= 1'b0;
      exit_dir   <= DIR_N;
      new_x      <= '0;
      new_y      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (req) begin
            cx_r   <= cur_x;
            cy_r   <= cur_y;
            dx_r   <= dx;
            dy_r   <= dy;
            room_r <= room;
            busy   <= 1'b1;
            state  <= S_CALC;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          wall_r <= 1'b0;
          px_r   <= px_c[9:0];
          py_r   <= py_c[9:0];
          if (any_exit) begin
            blocked    <= 1'b0;
            exit_valid <= 1'b1;
            done       <= 1'b1;
            state      <= S_DONE;
            new_x      <= cx_r;
            new_y      <= cy_r;
            if (exit_n) begin
              exit_dir <= DIR_N;
              new_y    <= 10'(PLAY_BOT - SPRITE_H);
            end else if (exit_s) begin
              exit_dir <= DIR_S;
              new_y    <= 10'(PLAY_TOP);
            end else if (exit_w) begin
              exit_dir <= DIR_W;
              new_x    <= 10'(SCREEN_W - SPRITE_W);
            end else begin
              exit_dir <= DIR_E;
              new_x    <= '0;
            end
          end else begin
            state <= S_Q_TL;
          end
        end
        S_Q_TL: begin wall_r <= hit; state <= S_Q_TR; end
        S_Q_TR: begin wall_r <= hit; state <= S_Q_BL; end
        S_Q_BL: begin wall_r <= hit; state <= S_Q_BR; end
        S_Q_BR: begin
          wall_r     <= hit;
          blocked    <= hit;
          exit_valid <= 1'b0;
          new_x      <= hit ? cx_r : px_r;
          new_y      <= hit ? cy_r : py_r;
          done       <= 1'b1;
          state      <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_room_collision_checker.sv
// Directed bench for room_collision_checker with a small tile map model.
module tb_room_collision_checker;

  logic       clk = 1'b0;
  logic       reset, req;
  logic [9:0] cur_x, cur_y, query_x, query_y, new_x, new_y;
  logic [3:0] dx, dy;
  logic [2:0] room, query_room;
  logic       tile_wall, busy, done, blocked, exit_valid;
  logic [1:0] exit_dir;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int lat, snap;
  logic [9:0] q2x, q2y;
  logic [2:0] q2r;
  logic       b1;

  always #5 clk = ~clk;

  room_collision_checker #(.SPRITE_W(16), .SPRITE_H(16)) dut (
    .clk(clk), .reset(reset), .req(req), .cur_x(cur_x), .cur_y(cur_y),
    .dx(dx), .dy(dy), .room(room), .query_x(query_x), .query_y(query_y),
    .query_room(query_room), .tile_wall(tile_wall), .busy(busy), .done(done),
    .blocked(blocked), .exit_valid(exit_valid), .exit_dir(exit_dir),
    .new_x(new_x), .new_y(new_y)
  );

  // Border walls with an east door at rows 7; room 1 adds a block at tile (10,10).
  function automatic logic tile_at(input logic [9:0] x, input logic [9:0] y, input logic [2:0] r);
    logic w;
    w = (x < 32) || (y < 32) || (y >= 448) || ((x >= 608) && !((y >= 224) && (y < 256)));
    if (r == 3'd1 && x >= 320 && x < 352 && y >= 320 && y < 352) w = 1'b1;
    return w;
  endfunction

  always_comb tile_wall = tile_at(query_x, query_y, query_room);

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_req(input logic [9:0] cx, input logic [9:0] cy,
                           input logic [3:0] ddx, input logic [3:0] ddy, input logic [2:0] rm);
    @(negedge clk);
    cur_x = cx; cur_y = cy; dx = ddx; dy = ddy; room = rm; req = 1'b1;
  endtask

  // Leaves the bench in the cycle after done; lat is -1 if done never came.
  task automatic run_move(input logic [9:0] cx, input logic [9:0] cy,
                          input logic [3:0] ddx, input logic [3:0] ddy, input logic [2:0] rm);
    start_req(cx, cy, ddx, ddy, rm);
    step();
    req = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) b1 = busy;
      if (c == 2) begin q2x = query_x; q2y = query_y; q2r = query_room; end
      if (done) begin lat = c; break; end
      step();
    end
    step();
  endtask

  task automatic expect_res(input string tag, input int elat, input logic eblk, input logic eev,
                            input logic [1:0] edir, input logic [9:0] ex, input logic [9:0] ey);
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".done_pulse"}, done, 1'b0);
    chk({tag, ".blocked"}, blocked, eblk);
    chk({tag, ".exit_valid"}, exit_valid, eev);
    if (eev) chk({tag, ".exit_dir"}, exit_dir, edir);
    chk({tag, ".new_x"}, new_x, ex);
    chk({tag, ".new_y"}, new_y, ey);
  endtask

  task automatic expect_reset_outputs(input string tag);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".blocked"}, blocked, 1'b0);
    chk({tag, ".exit_valid"}, exit_valid, 1'b0);
    chk({tag, ".exit_dir"}, exit_dir, 2'd0);
    chk({tag, ".new_x"}, new_x, 10'd0);
    chk({tag, ".new_y"}, new_y, 10'd0);
    chk({tag, ".query_x"}, query_x, 10'd0);
    chk({tag, ".query_y"}, query_y, 10'd0);
    chk({tag, ".query_room"}, query_room, 3'd0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; cur_x = '0; cur_y = '0; dx = '0; dy = '0; room = '0;
    step(); step();
    expect_reset_outputs("reset");
    reset = 1'b0;
    step();

    run_move(10'd100, 10'd100, 4'd4, 4'd0, 3'd0);
    expect_res("free", 6, 1'b0, 1'b0, 2'd0, 10'd104, 10'd100);
    chk("free.busy_c1", b1, 1'b1);
    chk("free.q_tl_x", q2x, 10'd104);
    chk("free.q_tl_y", q2y, 10'd100);
    chk("free.q_room", q2r, 3'd0);

    run_move(10'd36, 10'd100, 4'h8, 4'd0, 3'd0);
    expect_res("wall", 6, 1'b1, 1'b0, 2'd0, 10'd36, 10'd100);

    run_move(10'd300, 10'd36, 4'd0, 4'h8, 3'd0);
    expect_res("north", 2, 1'b0, 1'b1, 2'd0, 10'd300, 10'd432);

    run_move(10'd624, 10'd240, 4'd4, 4'd0, 3'd0);
    expect_res("east", 2, 1'b0, 1'b1, 2'd3, 10'd0, 10'd240);

    run_move(10'd2, 10'd34, 4'h8, 4'h8, 3'd0);
    expect_res("nw_prio", 2, 1'b0, 1'b1, 2'd0, 10'd2, 10'd432);

    run_move(10'd200, 10'd430, 4'd0, 4'd3, 3'd0);
    expect_res("south", 2, 1'b0, 1'b1, 2'd1, 10'd200, 10'd32);

    run_move(10'd200, 10'd429, 4'd0, 4'd3, 3'd0);
    expect_res("south_edge", 6, 1'b0, 1'b0, 2'd0, 10'd200, 10'd432);

    run_move(10'd4, 10'd200, 4'hB, 4'd0, 3'd0);
    expect_res("west", 2, 1'b0, 1'b1, 2'd2, 10'd624, 10'd200);

    run_move(10'd4, 10'd200, 4'hC, 4'd0, 3'd0);
    expect_res("west_edge", 6, 1'b1, 1'b0, 2'd0, 10'd4, 10'd200);

    run_move(10'd100, 10'd36, 4'd0, 4'hC, 3'd0);
    expect_res("north_edge", 6, 1'b0, 1'b0, 2'd0, 10'd100, 10'd32);

    run_move(10'd300, 10'd300, 4'd5, 4'd5, 3'd1);
    expect_res("br_room1", 6, 1'b1, 1'b0, 2'd0, 10'd300, 10'd300);
    chk("br_room1.q_room", q2r, 3'd1);
    chk("br_room1.q_tl_x", q2x, 10'd305);

    run_move(10'd300, 10'd300, 4'd5, 4'd5, 3'd0);
    expect_res("br_room0", 6, 1'b0, 1'b0, 2'd0, 10'd305, 10'd305);
    step(); step();
    chk("hold.new_x", new_x, 10'd305);

    run_move(10'd20, 10'd100, 4'd0, 4'd0, 3'd0);
    expect_res("zero_step", 6, 1'b1, 1'b0, 2'd0, 10'd20, 10'd100);

    // Second req during Q_TR must be dropped.
    snap = done_cnt;
    start_req(10'd100, 10'd100, 4'd4, 4'd0, 3'd0);
    step(); req = 1'b0;
    step(); step();
    cur_x = 10'd200; cur_y = 10'd200; dx = 4'd1; req = 1'b1;
    step(); req = 1'b0;
    for (int c = 0; c < 12; c++) step();
    chk("dropped_req.done_count", done_cnt - snap, 1);
    chk("dropped_req.new_x", new_x, 10'd104);
    chk("dropped_req.busy", busy, 1'b0);

    // Reset in cycle 4 aborts the move with no done.
    snap = done_cnt;
    start_req(10'd100, 10'd100, 4'd4, 4'd0, 3'd2);
    step(); req = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_reset_outputs("mid_reset");
    step();
    chk("mid_reset.no_done", done, 1'b0);
    chk("mid_reset.done_count", done_cnt - snap, 0);
    run_move(10'd200, 10'd200, 4'd2, 4'hD, 3'd0);
    expect_res("after_reset", 6, 1'b0, 1'b0, 2'd0, 10'd202, 10'd197);

    // A req in the done cycle starts the next check immediately.
    start_req(10'd100, 10'd100, 4'd4, 4'd0, 3'd0);
    step(); req = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin lat = c; break; end
      step();
    end
    chk("b2b.first_latency", lat, 6);
    chk("b2b.first_new_x", new_x, 10'd104);
    cur_x = 10'd300; cur_y = 10'd300; dx = 4'hD; dy = 4'd2; req = 1'b1;
    step(); req = 1'b0;
    chk("b2b.busy_calc", busy, 1'b1);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin lat = c; break; end
      step();
    end
    chk("b2b.second_latency", lat, 6);
    chk("b2b.second_new_x", new_x, 10'd297);
    chk("b2b.second_new_y", new_y, 10'd302);
    chk("b2b.blocked", blocked, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
